// File: rtl/demux_3_buffered.sv
// demux_3_buffered: routes words to three one-entry buffered valid/ready ports or discards them with a saturating drop count
module demux_3_buffered (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_sel,
  output logic        a_valid,
  input  logic        a_ready,
  output logic [31:0] a_data,
  output logic        b_valid,
  input  logic        b_ready,
  output logic [31:0] b_data,
  output logic        c_valid,
  input  logic        c_ready,
  output logic [31:0] c_data,
  output logic        drop_pulse,
  output logic [7:0]  drop_count
);
  logic [2:0]       full_q, full_d, rdy;
  logic [2:0][31:0] data_q, data_d;
  logic [3:0]       free;
  logic             drop_pulse_q, drop_pulse_d, accept;
  logic [7:0]       drop_count_q, drop_count_d;
  assign rdy        = {c_ready, b_ready, a_ready};
  assign free       = {1'b1, ~full_q | rdy};
  assign in_ready   = free[in_sel];
  assign accept     = in_valid && in_ready;
  assign a_valid    = full_q[0];
  assign b_valid    = full_q[1];
  assign c_valid    = full_q[2];
  assign a_data     = data_q[0];
  assign b_data     = data_q[1];
  assign c_data     = data_q[2];
  assign drop_pulse = drop_pulse_q;
  assign drop_count = drop_count_q;
  always_comb begin
    full_d = '0;
    data_d = data_q;
    for (int k = 0; k < 3; k++) begin
      full_d[k] = (accept && in_sel == 2'(k)) || (full_q[k] && !rdy[k]);
      data_d[k] = (accept && in_sel == 2'(k)) ? in_data : data_q[k];
    end
    drop_pulse_d = accept && in_sel == 2'd3;
    drop_count_d = (drop_pulse_d && drop_count_q != 8'hff) ? drop_count_q + 8'd1 : drop_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q       <= '0;
      data_q       <= '0;
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      full_q       <= full_d;
      data_q       <= data_d;
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end
endmodule

// File: tb/tb_demux_3_buffered.sv
// tb_demux_3_buffered: queue-model scoreboard plus directed scenarios for demux_3_buffered
module tb_demux_3_buffered;
  logic        clk = 0, rst = 0, in_valid = 0, in_ready;
  logic [31:0] in_data = 0, a_data, b_data, c_data;
  logic [1:0]  in_sel = 0;
  logic        a_valid, b_valid, c_valid, a_ready = 0, b_ready = 0, c_ready = 0, drop_pulse;
  logic [7:0]  drop_count;
  int          total = 0, bad = 0;
  logic [31:0] mq [3][$];
  logic [31:0] last [3];
  logic [2:0]  rdv;
  int          mcnt = 0;
  bit          mpulse = 0, seen = 0, macc;
  always #5 clk = ~clk;
  assign rdv = {c_ready, b_ready, a_ready};
  demux_3_buffered dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
    .drop_pulse(drop_pulse), .drop_count(drop_count)
  );
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic bit mrdy();
    if (in_sel == 2'd3) return 1'b1;
    return mq[in_sel].size() == 0 || rdv[in_sel];
  endfunction
  function automatic logic [31:0] mdata(int k);
    return mq[k].size() != 0 ? mq[k][0] : last[k];
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        mq[k].delete();
        last[k] = 0;
      end
      mcnt = 0;
      mpulse = 0;
      seen = 1;
    end else begin
      macc = in_valid && mrdy();
      for (int k = 0; k < 3; k++)
        if (mq[k].size() != 0 && rdv[k]) last[k] = mq[k].pop_front();
      if (macc && in_sel != 2'd3) mq[in_sel].push_back(in_data);
      mpulse = macc && in_sel == 2'd3;
      if (mpulse && mcnt != 255) mcnt++;
    end
  end
  always @(negedge clk) begin
    if (seen) begin
      chk("m_in_ready", {31'b0, in_ready}, {31'b0, mrdy()});
      chk("m_a_valid", {31'b0, a_valid}, {31'b0, mq[0].size() != 0});
      chk("m_b_valid", {31'b0, b_valid}, {31'b0, mq[1].size() != 0});
      chk("m_c_valid", {31'b0, c_valid}, {31'b0, mq[2].size() != 0});
      chk("m_a_data", a_data, mdata(0));
      chk("m_b_data", b_data, mdata(1));
      chk("m_c_data", c_data, mdata(2));
      chk("m_drop_pulse", {31'b0, drop_pulse}, {31'b0, mpulse});
      chk("m_drop_count", {24'b0, drop_count}, mcnt);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1;
    tick();
    tick();
    rst = 0;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    end
    chk("rst_valids", {29'b0, a_valid, b_valid, c_valid}, 32'd0);
    chk("rst_data", a_data | b_data | c_data, 32'd0);
    chk("rst_drop", {23'b0, drop_pulse, drop_count}, 32'd0);
    in_valid = 1; in_sel = 1; in_data = 32'hDEADBEEF;
    tick();
    in_valid = 0;
    #1;
    chk("b_valid_set", {31'b0, b_valid}, 32'd1);
    chk("b_data_set", b_data, 32'hDEADBEEF);
    chk("b_full_in_ready", {31'b0, in_ready}, 32'd0);
    chk("ac_idle", {30'b0, a_valid, c_valid}, 32'd0);
    tick();
    chk("b_data_held", b_data, 32'hDEADBEEF);
    in_valid = 1; in_sel = 0; in_data = 32'h11;
    tick();
    in_sel = 2; in_data = 32'h55;
    #1;
    chk("c_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 0;
    chk("c_valid_set", {31'b0, c_valid}, 32'd1);
    chk("c_data_set", c_data, 32'h55);
    chk("a_data_kept", a_data, 32'h11);
    a_ready = 1; b_ready = 1; c_ready = 1;
    tick();
    chk("drained", {29'b0, a_valid, b_valid, c_valid}, 32'd0);
    chk("a_data_retained", a_data, 32'h11);
    in_valid = 1; in_sel = 0;
    for (int i = 1; i <= 4; i++) begin
      in_data = i;
      #1;
      chk("burst_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      chk("burst_a_data", a_data, i);
      chk("burst_a_valid", {31'b0, a_valid}, 32'd1);
    end
    in_sel = 3;
    for (int i = 0; i < 260; i++) begin
      tick();
      chk("drop_pulse_hi", {31'b0, drop_pulse}, 32'd1);
      if (i == 9) chk("drop_count_10", {24'b0, drop_count}, 32'd10);
    end
    chk("drop_sat", {24'b0, drop_count}, 32'd255);
    chk("drop_no_valid", {29'b0, a_valid, b_valid, c_valid}, 32'd0);
    in_valid = 0;
    tick();
    chk("drop_pulse_lo", {31'b0, drop_pulse}, 32'd0);
    b_ready = 0; in_valid = 1; in_sel = 1; in_data = 32'h77;
    tick();
    rst = 1; b_ready = 1; in_data = 32'h88;
    tick();
    rst = 0; in_valid = 0;
    chk("rst_b_valid", {31'b0, b_valid}, 32'd0);
    chk("rst_b_data", b_data, 32'd0);
    chk("rst_drop_count", {24'b0, drop_count}, 32'd0);
    for (int i = 0; i < 10000; i++) begin
      in_valid = 1'($urandom);
      in_sel = 2'($urandom);
      in_data = $urandom;
      a_ready = 1'($urandom);
      b_ready = ($urandom_range(3) != 0);
      c_ready = ($urandom_range(3) == 0);
      tick();
    end
    in_valid = 0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
